// File: rtl/servo_pkg.sv
// servo_pkg: shared FSM state type and duty-range helpers for the servo
// controllers. All duty values are expressed in clocks of one PWM frame.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SLEW = 2'd2
  } servo_state_e;

  // 1 ms pulse in a 20 ms frame.
  function automatic logic [31:0] min_duty(input logic [31:0] period);
    return period / 32'd20;
  endfunction

  // 2 ms pulse in a 20 ms frame.
  function automatic logic [31:0] max_duty(input logic [31:0] period);
    return period / 32'd10;
  endfunction

  // Neutral position, midway between the two extremes.
  function automatic logic [31:0] center_duty(input logic [31:0] period);
    return (min_duty(period) + max_duty(period)) / 32'd2;
  endfunction

  // Linear map of an 8-bit position onto [min_duty, max_duty], floor division.
  function automatic logic [31:0] pos_to_duty(input logic [7:0]  pos,
                                              input logic [31:0] period);
    logic [31:0] lo;
    logic [31:0] span;
    lo   = min_duty(period);
    span = max_duty(period) - lo;
    return lo + (32'(pos) * span) / 32'd255;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// servo_frame_timer: free-running 0..PERIOD-1 counter, kept in step with the
// PWM counter; frame_tick marks the last clock of every frame.
module servo_frame_timer #(
  parameter int unsigned PERIOD = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic frame_tick
);

  localparam logic [31:0] LAST = 32'(PERIOD - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: wrap after the last clock of the frame.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 32'd1;
  end

  // Frame counter register.
  // NOTE: state uses non-blocking assignment so every flop samples pre-edge values whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign frame_tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: accepts 8-bit position commands, maps them to a 1..2 ms
// duty and slews duty_cycle toward that target by at most STEP per frame,
// updating only on frame boundaries.
// Optional feature macro: SERVO_WATCHDOG_EN (returns to centre when no
// command arrives for WDT_FRAMES frames).
module servo_slew_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned PERIOD     = 500_000,
  parameter int unsigned STEP       = 250,
  parameter int unsigned WDT_FRAMES = (5 * CLK_FREQ) / PERIOD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_pos,
  output logic        cmd_ready,
  output logic [31:0] duty_cycle,
  output logic [31:0] pwm_period,
  output logic        busy,
  output logic        done,
  output logic        wdt_fired
);

  localparam logic [31:0] PERIOD_W = 32'(PERIOD);
  localparam logic [31:0] STEP_W   = 32'(STEP);
  localparam logic [31:0] CENTER   = center_duty(PERIOD_W);

  servo_state_e state_q, state_d;
  logic [7:0]   pos_q, pos_d;
  logic [31:0]  target_q, target_d;
  logic [31:0]  duty_q, duty_d;
  logic         done_q, done_d;
  logic         cmd_ready_q, busy_q;
  logic [31:0]  stepped;
  logic [31:0]  load_duty;
  logic         handshake;
  logic         frame_tick;

  servo_frame_timer #(.PERIOD(PERIOD)) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick)
  );

  assign handshake = cmd_valid && cmd_ready_q;
  assign load_duty = pos_to_duty(pos_q, PERIOD_W);

  // One bounded step toward the target; lands exactly on it when close enough.
  always_comb begin
    if (target_q >= duty_q) begin
      stepped = (target_q - duty_q <= STEP_W) ? target_q : duty_q + STEP_W;
    end else begin
      stepped = (duty_q - target_q <= STEP_W) ? target_q : duty_q - STEP_W;
    end
  end

`ifdef SERVO_WATCHDOG_EN
  localparam logic [31:0] WDT_LAST = 32'(WDT_FRAMES - 1);
  logic [31:0] wdt_cnt_q, wdt_cnt_d;
  logic        wdt_fired_q, wdt_fired_d;
`endif

  // FSM next state: IDLE waits, LOAD maps the command, SLEW steps per frame.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;
    duty_d   = duty_q;
    done_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          pos_d   = cmd_pos;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        target_d = load_duty;
        if (load_duty == duty_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SLEW;
        end
      end
      ST_SLEW: begin
        // The frame step uses the old target even if a command lands now.
        if (frame_tick) begin
          duty_d = stepped;
          if (stepped == target_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        if (handshake) begin
          pos_d   = cmd_pos;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef SERVO_WATCHDOG_EN
    // A command in the expiry cycle clears the count, so the command wins.
    wdt_cnt_d   = wdt_cnt_q;
    wdt_fired_d = 1'b0;
    if (handshake) begin
      wdt_cnt_d = '0;
    end else if (frame_tick) begin
      if (wdt_cnt_q == WDT_LAST) begin
        wdt_cnt_d   = '0;
        wdt_fired_d = 1'b1;
        target_d    = CENTER;
        state_d     = ST_SLEW;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 32'd1;
      end
    end
`endif
  end

  // Control and datapath registers; reset snaps duty back to centre.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      target_q    <= CENTER;
      duty_q      <= CENTER;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      target_q    <= target_d;
      duty_q      <= duty_d;
      done_q      <= done_d;
      cmd_ready_q <= (state_d != ST_LOAD);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

`ifdef SERVO_WATCHDOG_EN
  // Watchdog frame counter and its one-cycle expiry pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  assign wdt_fired = 1'b0;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign duty_cycle = duty_q;
  assign pwm_period = PERIOD_W;

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// tb_servo_slew_ctrl: directed stimulus for servo_slew_ctrl with a frame-level
// reference model compared every cycle, plus hand-computed literal checks.
module tb_servo_slew_ctrl;

  localparam int PERIOD = 1000;
  localparam int STEP   = 5;
  localparam int WDT    = 4;
  localparam int MIN_D  = PERIOD / 20;          // 50
  localparam int MAX_D  = PERIOD / 10;          // 100
  localparam int CENTER = (MIN_D + MAX_D) / 2;  // 75

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_pos = 8'd0;
  logic        cmd_ready, busy, done, wdt_fired;
  logic [31:0] duty_cycle, pwm_period;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  servo_slew_ctrl #(
    .CLK_FREQ   (50_000),
    .PERIOD     (PERIOD),
    .STEP       (STEP),
    .WDT_FRAMES (WDT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_pos    (cmd_pos),
    .cmd_ready  (cmd_ready),
    .duty_cycle (duty_cycle),
    .pwm_period (pwm_period),
    .busy       (busy),
    .done       (done),
    .wdt_fired  (wdt_fired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int map_pos(input int p);
    return MIN_D + (p * (MAX_D - MIN_D)) / 255;
  endfunction

  int e_duty, m_target, m_pos, m_edges, m_wdt;
  bit e_ready, e_busy, e_done, e_wdt, m_loading, m_slewing;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_duty <= CENTER; m_target <= CENTER; m_pos <= 0; m_edges <= 0; m_wdt <= 0;
      e_ready <= 1'b1; e_busy <= 1'b0; e_done <= 1'b0; e_wdt <= 1'b0;
      m_loading <= 1'b0; m_slewing <= 1'b0;
    end else begin : upd
      automatic bit tick = (m_edges % PERIOD) == PERIOD - 1;
      automatic bit hs   = cmd_valid && e_ready;
      automatic int duty = e_duty;
      automatic int tgt  = m_target;
      automatic int pos  = m_pos;
      automatic int wc   = m_wdt;
      automatic int gap  = 0;
      automatic bit load = m_loading;
      automatic bit slew = m_slewing;
      automatic bit dn   = 1'b0;
      automatic bit wf   = 1'b0;
      if (m_loading) begin
        tgt  = map_pos(m_pos);
        load = 1'b0;
        if (tgt == duty) dn = 1'b1;
        else slew = 1'b1;
      end else begin
        if (m_slewing && tick) begin
          gap = tgt - duty;
          if (gap > STEP) duty = duty + STEP;
          else if (gap < -STEP) duty = duty - STEP;
          else begin
            duty = tgt; dn = 1'b1; slew = 1'b0;
          end
        end
        if (hs) begin
          load = 1'b1; slew = 1'b0; pos = int'(cmd_pos);
        end
      end
`ifdef SERVO_WATCHDOG_EN
      if (hs) wc = 0;
      else if (tick) begin
        wc = wc + 1;
        if (wc == WDT) begin
          wc = 0; wf = 1'b1; tgt = CENTER; load = 1'b0; slew = 1'b1;
        end
      end
`endif
      e_duty <= duty; m_target <= tgt; m_pos <= pos; m_wdt <= wc;
      e_done <= dn; e_wdt <= wf; m_loading <= load; m_slewing <= slew;
      e_ready <= !load; e_busy <= load || slew;
      m_edges <= m_edges + 1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("duty_cycle", duty_cycle, 32'(e_duty));
      check("cmd_ready", {31'd0, cmd_ready}, {31'd0, e_ready});
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("wdt_fired", {31'd0, wdt_fired}, {31'd0, e_wdt});
      check("pwm_period", pwm_period, 32'(PERIOD));
    end
  end

  // Monitor: history of duty values and pulse counts.
  logic [31:0] seen[$];
  logic [31:0] last_duty;
  int n_done = 0;
  int n_wdt  = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_duty <= 32'(CENTER);
    end else if (chk_en) begin
      if (duty_cycle !== last_duty) seen.push_back(duty_cycle);
      last_duty <= duty_cycle;
      n_done <= n_done + int'(done);
      n_wdt  <= n_wdt + int'(wdt_fired);
    end
  end

  // ---------------- stimulus helpers (drive at posedge + 1) ----------------
  task automatic send(input int p);
    bit acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_pos   = 8'(p);
    for (int i = 0; i < 8 && !acc; i++) begin
      acc = e_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    check("hs_accepted", {31'd0, acc}, 32'd1);
    check("ready_low_after_hs", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1;
    check("ready_back_after_load", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_changes(input int n, input int budget);
    int start = seen.size();
    int k = 0;
    while (seen.size() < start + n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("duty_changes_seen", {31'd0, seen.size() >= start + n}, 32'd1);
  endtask

  task automatic align_to_tick();
    int k = 0;
    while ((m_edges % PERIOD) != PERIOD - 1 && k < 2 * PERIOD) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  int exp_c[5]  = '{80, 85, 90, 95, 100};
  int exp_d[11] = '{70, 65, 60, 65, 70, 75, 80, 85, 90, 95, 100};
  int n0;

  initial begin
    // A: reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_duty", duty_cycle, 32'd75);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wdt", {31'd0, wdt_fired}, 32'd0);
    check("rst_period", pwm_period, 32'd1000);

`ifndef SERVO_WATCHDOG_EN
    // B: pos=128 maps to 75 == duty: done at T+2, no frame wait
    send(128);
    check("p128_done_t2", {31'd0, done}, 32'd1);
    check("p128_duty", duty_cycle, 32'd75);

    // C: pos=255 ramps 80..100, then done and busy low
    seen.delete();
    send(255);
    wait_done("c_done", 7 * PERIOD);
    check("c_busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("c_len", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) check("c_seq", seen[i], 32'(exp_c[i]));

    // D: back to centre, then pos=0 for three frames, then reverse to 255
    send(128);
    wait_done("d_center_done", 7 * PERIOD);
    @(posedge clk); #1;
    seen.delete();
    n0 = n_done;
    send(0);
    wait_changes(3, 4 * PERIOD);
    check("d_duty_60", duty_cycle, 32'd60);
    send(255);
    wait_done("d_done", 10 * PERIOD);
    check("d_duty_100", duty_cycle, 32'd100);
    @(posedge clk); #1;
    check("d_len", 32'(seen.size()), 32'd11);
    for (int i = 0; i < 11 && i < seen.size(); i++) check("d_seq", seen[i], 32'(exp_d[i]));
    check("d_single_done", 32'(n_done - n0), 32'd1);

    // E: handshake on the frame_tick edge: step toward old target first
    send(0);
    wait_changes(2, 3 * PERIOD);
    check("e_duty_90", duty_cycle, 32'd90);
    align_to_tick();
    n0 = n_done;
    send(255);
    check("e_coincident_step", duty_cycle, 32'd85);
    wait_done("e_done", 5 * PERIOD);
    check("e_duty_100", duty_cycle, 32'd100);
    @(posedge clk); #1;
    check("e_single_done", 32'(n_done - n0), 32'd1);

    // F: asynchronous reset mid-slew snaps duty to centre at once
    send(0);
    wait_changes(1, 2 * PERIOD);
    #3 rst_n = 1'b0;
    #1;
    check("f_rst_duty", duty_cycle, 32'd75);
    check("f_rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("f_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("no_wdt_pulses", 32'(n_wdt), 32'd0);
`else
    // G: watchdog fires four frames after the last command, returns to centre
    send(255);
    begin
      int k = 0;
      while (wdt_fired !== 1'b1 && k < 5 * PERIOD) begin
        @(posedge clk); #1;
        k++;
      end
    end
    check("g_wdt_fired", {31'd0, wdt_fired}, 32'd1);
    check("g_duty_at_fire", duty_cycle, 32'd95);
    wait_done("g_done", 6 * PERIOD);
    check("g_duty_center", duty_cycle, 32'd75);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
